instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch unit that drives the instruction ROM's asynchronous read port and assembles one- or two-byte instructions for the decode/execute stage. It holds the program counter and decides instruction length from the opcode nibble. It presents each instruction with a valid/ready handshake, accepts branch redirects, and freezes on HLT. It sits between instruction_memory and the control unit.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_addr  out  8  ROM read address; always equals the PC register
imem_data  in  8  ROM read data; combinational from imem_addr, valid in the same cycle
instr_byte  out  8  first byte of the current instruction (opcode[7:4], Rd[3:2], Rs[1:0])
instr_imm  out  8  second byte; 8'h00 for one-byte instructions
instr_pc  out  8  address of instr_byte
instr_valid  out  1  instruction outputs are valid
instr_ready  in  1  consumer accepts the instruction this cycle
redirect_en  in  1  single-cycle branch/jump request
redirect_pc  in  8  new PC when redirect_en=1
halted  out  1  HLT consumed; fetch frozen

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=FETCH1, instr_valid=0, instr_byte=0, instr_imm=0, instr_pc=0, halted=0.
- Two-byte opcodes, from a package constant: LDI 4'b1001, JMP 4'b1100, JZ 4'b1101. All other opcodes are one byte. HLT is 4'b1110.
- States: FETCH1, FETCH2, HOLD, HALT.
- FETCH1 (rising edge):
  - instr_byte<=imem_data; instr_pc<=pc; instr_imm<=0; pc<=pc+1.
  - Next state is FETCH2 if the opcode is two-byte, otherwise HOLD.
- FETCH2 (rising edge): instr_imm<=imem_data; pc<=pc+1; next state HOLD.
- HOLD:
  - instr_valid=1 and all instruction outputs stable.
  - On instr_ready=1: if the opcode is HLT, go to HALT; otherwise go to FETCH1.
  - On instr_ready=0: stay in HOLD.
- HALT: instr_valid=0, halted=1. pc and outputs are frozen. Only rst exits this state. redirect_en is ignored.
- instr_valid is a registered state decode: it is high only in HOLD.
- Latency: one-byte instruction is valid 1 cycle after FETCH1; two-byte instruction is valid 2 cycles after FETCH1. Peak throughput is one instruction per 2 cycles (one-byte) or per 3 cycles (two-byte).
- Redirect (any state except HALT):
  - pc<=redirect_pc; state<=FETCH1; any partial or held instruction is discarded; instr_valid is 0 in the next cycle.
  - Redirect beats instr_ready in the same cycle; the held instruction counts as consumed.
  - Redirect in FETCH2 aborts the immediate fetch.
- PC arithmetic is 8-bit modulo: 8'hFF+1 wraps to 8'h00. A two-byte opcode at 8'hFF takes its immediate from address 8'h00.
- HLT with instr_ready low is held indefinitely, not halted, until it is accepted.
- Reset during FETCH2 or HOLD discards the instruction. Fetch restarts at RESET_PC on the first edge after rst deasserts.
- No X on outputs after reset, regardless of imem_data.

Decomposition:
- Shared package cpu_isa_pkg:
  - opcode constants (NOP, ADD, SUB, LDI, ST, JMP, JZ, HLT);
  - fetch state encoding;
  - function is_two_byte(opcode).
- No sub-module. The PC register, FSM and output registers stay in a single module; instruction_memory remains a separate instance at the CPU top.

Test Plan:
- ROM {0:8'h90, 1:8'h05, 2:8'h11, 3:8'hE0}, instr_ready=1 → outputs in order:
  - (pc 0, 8'h90, imm 8'h05)
  - (pc 2, 8'h11, imm 0)
  - (pc 3, 8'hE0)
  - then halted=1 and imem_addr stuck at 4.
- Same ROM, instr_ready=0 for 5 cycles during the first HOLD → instr_valid stays 1 and outputs are stable (90/05). After instr_ready rises, the next instruction is from pc 2.
- During HOLD at pc 2, assert redirect_en=1, redirect_pc=8'h40 with instr_ready=1 → next cycle instr_valid=0 and imem_addr=8'h40. The next valid has instr_pc=8'h40.
- RESET_PC=8'hFF, ROM[FF]=8'h9C, ROM[0]=8'h2A → one valid instruction with instr_pc=8'hFF, byte 8'h9C, imm 8'h2A. The next fetch is from 8'h01.
- Assert rst mid-FETCH2, then release → instr_valid=0 and halted=0 immediately. The first valid after release has instr_pc=RESET_PC.
- After halt, pulse redirect_en and instr_ready → no change: halted=1, instr_valid=0, imem_addr frozen.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcode constants, fetch FSM state encoding and
// the instruction-length decode used by the fetch unit.
package cpu_isa_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_JZ  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1110;

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        HOLD   = 2'd2,
        HALT   = 2'd3
    } fetch_state_t;

    function automatic logic is_two_byte(input logic [3:0] opcode);
        return (opcode == OP_LDI) || (opcode == OP_JMP) || (opcode == OP_JZ);
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, reads one- or two-byte instructions from the ROM
// and presents them to the control unit with a valid/ready handshake.
module instruction_fetch
    import cpu_isa_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] instr_byte,
    output logic [7:0] instr_imm,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       redirect_en,
    input  logic [7:0] redirect_pc,
    output logic       halted
);

    fetch_state_t state, state_next;
    logic [7:0]   pc, pc_next;
    logic         cap_byte, cap_imm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH1;
            pc         <= RESET_PC;
            instr_byte <= '0;
            instr_imm  <= '0;
            instr_pc   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (cap_byte) begin
                instr_byte <= imem_data;
                instr_pc   <= pc;
                instr_imm  <= '0;
            end
            if (cap_imm) begin
                instr_imm <= imem_data;
            end
        end
    end

    // Redirect takes priority over every state except HALT, including a
    // pending instr_ready in HOLD; no output register is touched when it wins.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        cap_byte   = 1'b0;
        cap_imm    = 1'b0;
        if (redirect_en && state != HALT) begin
            state_next = FETCH1;
            pc_next    = redirect_pc;
        end else begin
            case (state)
                FETCH1: begin
                    cap_byte   = 1'b1;
                    pc_next    = pc + 8'd1;
                    state_next = is_two_byte(imem_data[7:4]) ? FETCH2 : HOLD;
                end
                FETCH2: begin
                    cap_imm    = 1'b1;
                    pc_next    = pc + 8'd1;
                    state_next = HOLD;
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_next = (instr_byte[7:4] == OP_HLT) ? HALT : FETCH1;
                    end
                end
                HALT: begin
                    state_next = HALT;
                end
                default: begin
                    state_next = FETCH1;
                end
            endcase
        end
    end

    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances (RESET_PC 00 and FF),
// each reading its own behavioural ROM.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom_a [256];
    logic [7:0] rom_b [256];

    logic       rst_a, ready_a, redir_en_a;
    logic [7:0] redir_pc_a;
    logic [7:0] addr_a, data_a, byte_a, imm_a, ipc_a;
    logic       valid_a, halted_a;

    logic       rst_b, ready_b, redir_en_b;
    logic [7:0] redir_pc_b;
    logic [7:0] addr_b, data_b, byte_b, imm_b, ipc_b;
    logic       valid_b, halted_b;

    assign data_a = rom_a[addr_a];
    assign data_b = rom_b[addr_b];

    instruction_fetch #(.RESET_PC(8'h00)) u_dut_a (
        .clk(clk), .rst(rst_a), .imem_addr(addr_a), .imem_data(data_a),
        .instr_byte(byte_a), .instr_imm(imm_a), .instr_pc(ipc_a),
        .instr_valid(valid_a), .instr_ready(ready_a),
        .redirect_en(redir_en_a), .redirect_pc(redir_pc_a), .halted(halted_a)
    );

    instruction_fetch #(.RESET_PC(8'hFF)) u_dut_b (
        .clk(clk), .rst(rst_b), .imem_addr(addr_b), .imem_data(data_b),
        .instr_byte(byte_b), .instr_imm(imm_b), .instr_pc(ipc_b),
        .instr_valid(valid_b), .instr_ready(ready_b),
        .redirect_en(redir_en_b), .redirect_pc(redir_pc_b), .halted(halted_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_a[i] = 8'h00;
            rom_b[i] = 8'h00;
        end
        rom_a[0] = 8'h90; rom_a[1] = 8'h05; rom_a[2] = 8'h11; rom_a[3] = 8'hE0;
        rom_a[8'h40] = 8'h25;
        rom_b[8'hFF] = 8'h9C; rom_b[0] = 8'h2A; rom_b[1] = 8'h11;

        rst_a = 1'b1; ready_a = 1'b1; redir_en_a = 1'b0; redir_pc_a = 8'h00;
        rst_b = 1'b1; ready_b = 1'b0; redir_en_b = 1'b0; redir_pc_b = 8'h00;
        step(2);

        // Reset state
        check("rst_valid",  {7'd0, valid_a},  8'h00);
        check("rst_halted", {7'd0, halted_a}, 8'h00);
        check("rst_byte",   byte_a, 8'h00);
        check("rst_imm",    imm_a,  8'h00);
        check("rst_ipc",    ipc_a,  8'h00);
        check("rst_addr",   addr_a, 8'h00);

        // Straight-line program, consumer always ready
        rst_a = 1'b0;
        step(1);
        check("f1_valid", {7'd0, valid_a}, 8'h00);
        check("f1_addr",  addr_a, 8'h01);
        step(1);
        check("i0_valid", {7'd0, valid_a}, 8'h01);
        check("i0_pc",    ipc_a,  8'h00);
        check("i0_byte",  byte_a, 8'h90);
        check("i0_imm",   imm_a,  8'h05);
        step(1);
        check("i0_acc_valid", {7'd0, valid_a}, 8'h00);
        step(1);
        check("i1_valid", {7'd0, valid_a}, 8'h01);
        check("i1_pc",    ipc_a,  8'h02);
        check("i1_byte",  byte_a, 8'h11);
        check("i1_imm",   imm_a,  8'h00);
        step(2);
        check("i2_valid", {7'd0, valid_a}, 8'h01);
        check("i2_pc",    ipc_a,  8'h03);
        check("i2_byte",  byte_a, 8'hE0);
        step(1);
        check("hlt_halted", {7'd0, halted_a}, 8'h01);
        check("hlt_valid",  {7'd0, valid_a},  8'h00);
        check("hlt_addr",   addr_a, 8'h04);
        step(3);
        check("hlt_addr_hold", addr_a, 8'h04);

        // Halt ignores redirect and ready
        redir_en_a = 1'b1; redir_pc_a = 8'h40; ready_a = 1'b1;
        step(1);
        redir_en_a = 1'b0;
        step(1);
        check("hlt_redir_halted", {7'd0, halted_a}, 8'h01);
        check("hlt_redir_valid",  {7'd0, valid_a},  8'h00);
        check("hlt_redir_addr",   addr_a, 8'h04);
        check("hlt_redir_ipc",    ipc_a,  8'h03);

        // Back-pressure in the first HOLD
        rst_a = 1'b1; ready_a = 1'b0;
        step(1);
        check("rst2_halted", {7'd0, halted_a}, 8'h00);
        rst_a = 1'b0;
        step(2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {7'd0, valid_a}, 8'h01);
            check("bp_byte",  byte_a, 8'h90);
            check("bp_imm",   imm_a,  8'h05);
            check("bp_addr",  addr_a, 8'h02);
            step(1);
        end
        ready_a = 1'b1;
        step(1);
        check("bp_rel_valid", {7'd0, valid_a}, 8'h00);
        step(1);
        check("bp_next_pc",   ipc_a,  8'h02);
        check("bp_next_byte", byte_a, 8'h11);

        // Redirect beats ready in HOLD
        redir_en_a = 1'b1; redir_pc_a = 8'h40;
        step(1);
        redir_en_a = 1'b0;
        check("rd_valid", {7'd0, valid_a}, 8'h00);
        check("rd_addr",  addr_a, 8'h40);
        step(1);
        check("rd_new_valid", {7'd0, valid_a}, 8'h01);
        check("rd_new_pc",    ipc_a,  8'h40);
        check("rd_new_byte",  byte_a, 8'h25);

        // Reset during FETCH2
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        step(1);
        rst_a = 1'b1;
        #1;
        check("mid_rst_valid",  {7'd0, valid_a},  8'h00);
        check("mid_rst_halted", {7'd0, halted_a}, 8'h00);
        check("mid_rst_byte",   byte_a, 8'h00);
        check("mid_rst_addr",   addr_a, 8'h00);
        step(1);
        rst_a = 1'b0;
        step(2);
        check("mid_rst_rv_valid", {7'd0, valid_a}, 8'h01);
        check("mid_rst_rv_pc",    ipc_a, 8'h00);
        check("mid_rst_rv_imm",   imm_a, 8'h05);

        // PC wrap with RESET_PC = FF
        check("wrap_rst_addr", addr_b, 8'hFF);
        rst_b = 1'b0;
        step(2);
        check("wrap_valid", {7'd0, valid_b}, 8'h01);
        check("wrap_pc",    ipc_b,  8'hFF);
        check("wrap_byte",  byte_b, 8'h9C);
        check("wrap_imm",   imm_b,  8'h2A);
        check("wrap_addr",  addr_b, 8'h01);
        ready_b = 1'b1;
        step(2);
        check("wrap_next_pc",   ipc_b,  8'h01);
        check("wrap_next_byte", byte_b, 8'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
